// File: rtl/sm3_msg_arb_pkg.sv
// Shared state encoding and small helpers for the SM3 message arbiter.
// One-hot states keep the per-state decode to a single flop bit.
package sm3_msg_arb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_ARB  = 4'b0010,
    ST_XFER = 4'b0100,
    ST_WAIT = 4'b1000
  } arb_state_e;

  function automatic int wrap_inc(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/sm3_msg_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
// Kept standalone so a multi-core scheduler can reuse it.
module sm3_msg_arb_rr_pick #(
  parameter int REQ_NUM = 4,
  parameter int IDW     = 2
) (
  input  logic [REQ_NUM-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic               gnt_vld_o,
  output logic [IDW-1:0]     gnt_id_o
);

  logic [IDW-1:0] w_idx;

  // Scan from the farthest offset down so the closest request to ptr wins last.
  always_comb begin
    gnt_vld_o = 1'b0;
    gnt_id_o  = '0;
    w_idx     = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      w_idx = IDW'((int'(ptr_i) + i) % REQ_NUM);
      if (req_i[w_idx]) begin
        gnt_vld_o = 1'b1;
        gnt_id_o  = w_idx;
      end
    end
  end

endmodule

// File: rtl/sm3_msg_arb.sv
// Message-granular round-robin arbiter in front of one SM3 pad/compress core.
// Owner keeps the core input from grant until its digest-done pulse returns.
module sm3_msg_arb
  import sm3_msg_arb_pkg::*;
#(
  parameter int REQ_NUM = 4,
  parameter int DW      = 32,
  parameter int IDW     = 2,
  localparam int BW     = DW / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REQ_NUM*DW-1:0] req_d_i,
  input  logic [REQ_NUM*BW-1:0] req_vld_byte_i,
  input  logic [REQ_NUM-1:0]    req_vld_i,
  input  logic [REQ_NUM-1:0]    req_lst_i,
  output logic [REQ_NUM-1:0]    req_rdy_o,
  output logic [DW-1:0]         msg_inpt_d_o,
  output logic [BW-1:0]         msg_inpt_vld_byte_o,
  output logic                  msg_inpt_vld_o,
  output logic                  msg_inpt_lst_o,
  input  logic                  msg_inpt_rdy_i,
  input  logic                  dgst_done_i,
  output logic [REQ_NUM-1:0]    dgst_done_o,
  output logic [IDW-1:0]        gnt_id_o,
  output logic                  busy_o,
  output logic                  err_o
);

  arb_state_e     r_state;
  arb_state_e     w_next_state;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] r_gnt_id;
  logic           r_err;
  logic           w_err_evt;
  logic           w_pick_vld;
  logic [IDW-1:0] w_pick_id;
  logic [IDW-1:0] w_next_ptr;
  logic [DW-1:0]  w_src_d;
  logic [BW-1:0]  w_src_vb;
  logic           w_src_vld;
  logic           w_src_lst;

  sm3_msg_arb_rr_pick #(
    .REQ_NUM (REQ_NUM),
    .IDW     (IDW)
  ) u_pick (
    .req_i     (req_vld_i),
    .ptr_i     (r_rr_ptr),
    .gnt_vld_o (w_pick_vld),
    .gnt_id_o  (w_pick_id)
  );

  assign w_next_ptr = IDW'(wrap_inc(int'(w_pick_id), REQ_NUM));
  assign w_src_d    = req_d_i[r_gnt_id*DW +: DW];
  assign w_src_vb   = req_vld_byte_i[r_gnt_id*BW +: BW];
  assign w_src_vld  = req_vld_i[r_gnt_id];
  assign w_src_lst  = req_lst_i[r_gnt_id];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_gnt_id <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_ARB && w_pick_vld) begin
        r_gnt_id <= w_pick_id;
        r_rr_ptr <= w_next_ptr;
      end
      if (w_err_evt) r_err <= 1'b1;
    end
  end

  // Only XFER passes the owner through; every other state parks the core port at zero.
  always_comb begin
    w_next_state        = r_state;
    req_rdy_o           = '0;
    msg_inpt_d_o        = '0;
    msg_inpt_vld_byte_o = '0;
    msg_inpt_vld_o      = 1'b0;
    msg_inpt_lst_o      = 1'b0;
    dgst_done_o         = '0;
    w_err_evt           = 1'b0;
    case (r_state)
      ST_IDLE: if (|req_vld_i) w_next_state = ST_ARB;
      ST_ARB:  w_next_state = w_pick_vld ? ST_XFER : ST_IDLE;
      ST_XFER: begin
        msg_inpt_d_o        = w_src_d;
        msg_inpt_vld_byte_o = w_src_vb;
        msg_inpt_vld_o      = w_src_vld;
        msg_inpt_lst_o      = w_src_lst;
        req_rdy_o[r_gnt_id] = msg_inpt_rdy_i;
        if (w_src_vld && msg_inpt_rdy_i) begin
          if (w_src_lst) w_next_state = ST_WAIT;
          else if (w_src_vb != '1) w_err_evt = 1'b1;
        end
      end
      ST_WAIT: begin
        if (dgst_done_i) begin
          dgst_done_o[r_gnt_id] = 1'b1;
          w_next_state          = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (dgst_done_i && r_state != ST_WAIT) w_err_evt = 1'b1;
  end

  assign gnt_id_o = r_gnt_id;
  assign busy_o   = (r_state != ST_IDLE);
  assign err_o    = r_err;

endmodule

// File: tb/tb_sm3_msg_arb.sv
// Scoreboard bench for sm3_msg_arb: expected beats queued at drive time,
// popped by a negedge monitor whenever the core port accepts a beat.
module tb_sm3_msg_arb;

  localparam int REQ_NUM = 4;
  localparam int DW      = 32;
  localparam int BW      = 4;
  localparam int IDW     = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [REQ_NUM*DW-1:0] req_d_i;
  logic [REQ_NUM*BW-1:0] req_vld_byte_i;
  logic [REQ_NUM-1:0]    req_vld_i;
  logic [REQ_NUM-1:0]    req_lst_i;
  logic [REQ_NUM-1:0]    req_rdy_o;
  logic [DW-1:0]         msg_inpt_d_o;
  logic [BW-1:0]         msg_inpt_vld_byte_o;
  logic                  msg_inpt_vld_o;
  logic                  msg_inpt_lst_o;
  logic                  msg_inpt_rdy_i;
  logic                  dgst_done_i;
  logic [REQ_NUM-1:0]    dgst_done_o;
  logic [IDW-1:0]        gnt_id_o;
  logic                  busy_o;
  logic                  err_o;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] d;
    logic [3:0]  vb;
    logic        lst;
  } beat_t;

  beat_t expQ[$];
  int    checks = 0;
  int    errors = 0;

  sm3_msg_arb dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_d_i             (req_d_i),
    .req_vld_byte_i      (req_vld_byte_i),
    .req_vld_i           (req_vld_i),
    .req_lst_i           (req_lst_i),
    .req_rdy_o           (req_rdy_o),
    .msg_inpt_d_o        (msg_inpt_d_o),
    .msg_inpt_vld_byte_o (msg_inpt_vld_byte_o),
    .msg_inpt_vld_o      (msg_inpt_vld_o),
    .msg_inpt_lst_o      (msg_inpt_lst_o),
    .msg_inpt_rdy_i      (msg_inpt_rdy_i),
    .dgst_done_i         (dgst_done_i),
    .dgst_done_o         (dgst_done_o),
    .gnt_id_o            (gnt_id_o),
    .busy_o              (busy_o),
    .err_o               (err_o)
  );

  always #5 clk = ~clk;

  function automatic beat_t mkBeat(input int src, input logic [31:0] d, input logic [3:0] vb, input logic lst);
    beat_t b;
    b.src = 2'(src);
    b.d   = d;
    b.vb  = vb;
    b.lst = lst;
    return b;
  endfunction

  task automatic monitor();
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && msg_inpt_vld_o && msg_inpt_rdy_i) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL beat_unexpected: got id=%0d d=%h lst=%b, required no beat", gnt_id_o, msg_inpt_d_o, msg_inpt_lst_o);
        end else begin
          e = expQ.pop_front();
          if ({gnt_id_o, msg_inpt_d_o, msg_inpt_vld_byte_o, msg_inpt_lst_o} !== {e.src, e.d, e.vb, e.lst}) begin
            errors++;
            $display("[TB] FAIL beat_data: got id=%0d d=%h vb=%b lst=%b, required id=%0d d=%h vb=%b lst=%b",
                     gnt_id_o, msg_inpt_d_o, msg_inpt_vld_byte_o, msg_inpt_lst_o, e.src, e.d, e.vb, e.lst);
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    req_d_i        = '0;
    req_vld_byte_i = '0;
    req_vld_i      = '0;
    req_lst_i      = '0;
    msg_inpt_rdy_i = 1'b1;
    dgst_done_i    = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Source-side driver: holds each beat until the arbiter shows ready for it.
  task automatic send_msg(input int src, input int nbeats, input logic [31:0] base,
                          input logic [3:0] midvb, input logic [3:0] lastvb,
                          input bit toggle, output int cycles);
    int          b = 0;
    int          n = 0;
    bit          presented = 0;
    beat_t       e;
    logic [3:0]  expRdy;
    while (b < nbeats && n < 100) begin
      e = mkBeat(src, base + 32'(b), (b == nbeats - 1) ? lastvb : midvb, (b == nbeats - 1));
      if (!presented) begin
        expQ.push_back(e);
        presented = 1;
      end
      req_d_i[src*DW +: DW]        = e.d;
      req_vld_byte_i[src*BW +: BW] = e.vb;
      req_vld_i[src]               = 1'b1;
      req_lst_i[src]               = e.lst;
      msg_inpt_rdy_i               = toggle ? (n % 2 == 0) : 1'b1;
      @(negedge clk);
      if (n >= 2) begin
        expRdy = msg_inpt_rdy_i ? (4'b0001 << src) : 4'b0000;
        checks++;
        if (req_rdy_o !== expRdy) begin
          errors++;
          $display("[TB] FAIL req_rdy cycle %0d: got %b, required %b", n, req_rdy_o, expRdy);
        end
      end
      if (req_rdy_o[src]) begin
        b++;
        presented = 0;
      end
      @(posedge clk); #1;
      n++;
    end
    req_vld_i[src] = 1'b0;
    req_lst_i[src] = 1'b0;
    msg_inpt_rdy_i = 1'b1;
    cycles         = n;
    if (b < nbeats) begin
      checks++;
      errors++;
      $display("[TB] FAIL send_timeout: got %0d beats, required %0d", b, nbeats);
    end
  endtask

  task automatic pulse_done(input int src);
    logic [3:0] expDone;
    expDone     = 4'b0001 << src;
    dgst_done_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({dgst_done_o, msg_inpt_vld_o, req_rdy_o} !== {expDone, 1'b0, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL done_route: got done=%b vld=%b rdy=%b, required done=%b vld=0 rdy=0000",
               dgst_done_o, msg_inpt_vld_o, req_rdy_o, expDone);
    end
    @(posedge clk); #1;
    dgst_done_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_done: got busy=%b, required 0", busy_o);
    end
  endtask

  // Waits for the last beat of the current message, checks the owner, then completes it.
  task automatic run_one(input int expSrc, input bit clearSrc);
    bit found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (msg_inpt_vld_o && msg_inpt_rdy_i && msg_inpt_lst_o) begin
        found = 1;
        checks++;
        if (gnt_id_o !== 2'(expSrc)) begin
          errors++;
          $display("[TB] FAIL grant_order: got %0d, required %0d", gnt_id_o, expSrc);
        end
      end
      @(posedge clk); #1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_timeout: got no last beat, required source %0d", expSrc);
    end
    if (clearSrc) begin
      req_vld_i[expSrc] = 1'b0;
      req_lst_i[expSrc] = 1'b0;
    end
    pulse_done(expSrc);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({req_rdy_o, msg_inpt_vld_o, msg_inpt_lst_o, msg_inpt_d_o, dgst_done_o, gnt_id_o, busy_o, err_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got rdy=%b vld=%b d=%h done=%b id=%0d busy=%b err=%b, required all 0",
               req_rdy_o, msg_inpt_vld_o, msg_inpt_d_o, dgst_done_o, gnt_id_o, busy_o, err_o);
    end
  endtask

  task automatic test_single();
    int cyc;
    do_reset();
    send_msg(0, 3, 32'h61626380, 4'hF, 4'hF, 1'b0, cyc);
    checks++;
    if (cyc !== 5) begin
      errors++;
      $display("[TB] FAIL single_latency: got %0d cycles, required 5", cyc);
    end
    pulse_done(0);
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int k = 0; k < REQ_NUM; k++) begin
      req_d_i[k*DW +: DW]        = 32'hA0 + 32'(k);
      req_vld_byte_i[k*BW +: BW] = 4'hF;
      req_lst_i[k]               = 1'b1;
      req_vld_i[k]               = 1'b1;
    end
    for (int m = 0; m < 5; m++) begin
      expQ.push_back(mkBeat(order[m], 32'hA0 + 32'(order[m]), 4'hF, 1'b1));
      run_one(order[m], 1'b0);
    end
    req_vld_i = '0;
    req_lst_i = '0;
  endtask

  task automatic test_rdy_toggle();
    int cyc;
    do_reset();
    send_msg(2, 4, 32'hC0DE0000, 4'hF, 4'hF, 1'b1, cyc);
    checks++;
    if (cyc !== 9) begin
      errors++;
      $display("[TB] FAIL toggle_cycles: got %0d, required 9", cyc);
    end
    pulse_done(2);
  endtask

  task automatic test_err_done();
    do_reset();
    dgst_done_i = 1'b1;
    @(negedge clk);
    checks++;
    if (dgst_done_o !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL stray_done_routed: got %b, required 0000", dgst_done_o);
    end
    @(posedge clk); #1;
    dgst_done_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_sticky: got %b, required 1", err_o);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({err_o, busy_o} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL err_clear: got err=%b busy=%b, required 0 0", err_o, busy_o);
    end
  endtask

  task automatic test_rst_mid_xfer();
    bit found = 0;
    do_reset();
    expQ.push_back(mkBeat(1, 32'h11110000, 4'hF, 1'b0));
    req_d_i[1*DW +: DW]        = 32'h11110000;
    req_vld_byte_i[1*BW +: BW] = 4'hF;
    req_lst_i[1]               = 1'b0;
    req_vld_i[1]               = 1'b1;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk);
      if (req_rdy_o[1]) found = 1;
      @(posedge clk); #1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL src1_grant_timeout: got no ready, required ready for source 1");
    end
    req_d_i[1*DW +: DW] = 32'h11110001;
    msg_inpt_rdy_i      = 1'b0;
    rst                 = 1'b1;
    @(posedge clk); #1;
    rst            = 1'b0;
    msg_inpt_rdy_i = 1'b1;
    req_vld_i[1]   = 1'b0;
    for (int k = 0; k < REQ_NUM; k += 3) begin
      req_d_i[k*DW +: DW]        = 32'hB0 + 32'(k);
      req_vld_byte_i[k*BW +: BW] = 4'hF;
      req_lst_i[k]               = 1'b1;
      req_vld_i[k]               = 1'b1;
    end
    expQ.push_back(mkBeat(0, 32'hB0, 4'hF, 1'b1));
    expQ.push_back(mkBeat(3, 32'hB3, 4'hF, 1'b1));
    @(negedge clk);
    checks++;
    if ({req_rdy_o, msg_inpt_vld_o, busy_o} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL rst_drop: got rdy=%b vld=%b busy=%b, required 0000 0 0", req_rdy_o, msg_inpt_vld_o, busy_o);
    end
    @(posedge clk); #1;
    run_one(0, 1'b1);
    run_one(3, 1'b1);
  endtask

  task automatic test_vbyte_err();
    int cyc;
    do_reset();
    send_msg(0, 2, 32'h22220000, 4'hF, 4'b0111, 1'b0, cyc);
    pulse_done(0);
    checks++;
    if (err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL partial_last_ok: got err=%b, required 0", err_o);
    end
    send_msg(1, 2, 32'h33330000, 4'b0111, 4'hF, 1'b0, cyc);
    pulse_done(1);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL partial_mid_err: got err=%b, required 1", err_o);
    end
  endtask

  initial begin
    rst            = 1'b1;
    req_d_i        = '0;
    req_vld_byte_i = '0;
    req_vld_i      = '0;
    req_lst_i      = '0;
    msg_inpt_rdy_i = 1'b1;
    dgst_done_i    = 1'b0;
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_round_robin();
    test_rdy_toggle();
    test_err_done();
    test_rst_mid_xfer();
    test_vbyte_err();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL beats_lost: got %0d beats never transferred, required 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
